// File: rtl/fee_request_arbiter.sv
// Round-robin arbiter that shares one fee calculator among NUM_LANES exit lanes.
// A grant latches the lane's operands, fires a one-cycle start pulse and returns the fee with a done pulse.
module fee_request_arbiter #(
    parameter int NUM_LANES = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_LANES-1:0]      lane_req,
    input  logic [32*NUM_LANES-1:0]   lane_entry_time,
    input  logic [32*NUM_LANES-1:0]   lane_exit_time,
    input  logic [8*NUM_LANES-1:0]    lane_vehicle_id,
    output logic [NUM_LANES-1:0]      lane_grant,
    output logic [NUM_LANES-1:0]      lane_done,
    output logic [7:0]                lane_fee,
    output logic                      lane_error,
    output logic [31:0]               calc_entry_time,
    output logic [31:0]               calc_exit_time,
    output logic [7:0]                calc_vehicle_id,
    output logic                      calculate_fee,
    input  logic [7:0]                fee_amount,
    input  logic                      fee_valid,
    output logic                      busy
);

    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [NUM_LANES-1:0] ONE_LANE = NUM_LANES'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_r, state_nx_s;
    logic [LW-1:0]          ptr_r, ptr_nx_s;
    logic [LW-1:0]          win_r, win_nx_s;
    logic [CW-1:0]          cnt_r, cnt_nx_s;
    logic [NUM_LANES-1:0]   grant_r, grant_nx_s;
    logic [NUM_LANES-1:0]   done_r, done_nx_s;
    logic [7:0]             fee_r, fee_nx_s;
    logic                   error_r, error_nx_s;
    logic [31:0]            entry_r, entry_nx_s;
    logic [31:0]            exit_r, exit_nx_s;
    logic [7:0]             id_r, id_nx_s;
    logic                   start_r, start_nx_s;
    logic                   busy_r, busy_nx_s;

    logic                   found_s;
    logic [LW-1:0]          pick_s;
    logic [LW-1:0]          cand_s;

    // Round-robin search: first requesting lane strictly after the pointer, wrapping.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        cand_s  = '0;
        for (int off = 1; off <= NUM_LANES; off++) begin
            cand_s = LW'((int'(ptr_r) + off) % NUM_LANES);
            if (!found_s && lane_req[cand_s]) begin
                found_s = 1'b1;
                pick_s  = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic for the grant / wait / done sequence.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        win_nx_s   = win_r;
        cnt_nx_s   = cnt_r;
        grant_nx_s = grant_r;
        done_nx_s  = '0;
        fee_nx_s   = fee_r;
        error_nx_s = 1'b0;
        entry_nx_s = entry_r;
        exit_nx_s  = exit_r;
        id_nx_s    = id_r;
        start_nx_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    state_nx_s = WAIT;
                    win_nx_s   = pick_s;
                    cnt_nx_s   = '0;
                    grant_nx_s = ONE_LANE << pick_s;
                    entry_nx_s = lane_entry_time[32*pick_s +: 32];
                    exit_nx_s  = lane_exit_time[32*pick_s +: 32];
                    id_nx_s    = lane_vehicle_id[8*pick_s +: 8];
                    start_nx_s = 1'b1;
                end else begin
                    grant_nx_s = '0;
                end
            end
            WAIT: begin
                // A strobe coincident with the start pulse belongs to no operation of ours.
                if (fee_valid && !start_r) begin
                    state_nx_s = DONE;
                    fee_nx_s   = fee_amount;
                    done_nx_s  = grant_r;
                    grant_nx_s = '0;
                    ptr_nx_s   = win_r;
                end else if (cnt_r == CW'(TIMEOUT)) begin
                    state_nx_s = DONE;
                    fee_nx_s   = 8'hFF;
                    error_nx_s = 1'b1;
                    done_nx_s  = grant_r;
                    grant_nx_s = '0;
                    ptr_nx_s   = win_r;
                end else begin
                    cnt_nx_s = cnt_r + CW'(1);
                end
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                grant_nx_s = '0;
            end
        endcase
        busy_nx_s = (state_nx_s != IDLE);
    end

    // State and output registers; reset clears everything and points priority at lane 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            ptr_r   <= LW'(NUM_LANES - 1);
            win_r   <= '0;
            cnt_r   <= '0;
            grant_r <= '0;
            done_r  <= '0;
            fee_r   <= 8'h00;
            error_r <= 1'b0;
            entry_r <= 32'd0;
            exit_r  <= 32'd0;
            id_r    <= 8'd0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
            win_r   <= win_nx_s;
            cnt_r   <= cnt_nx_s;
            grant_r <= grant_nx_s;
            done_r  <= done_nx_s;
            fee_r   <= fee_nx_s;
            error_r <= error_nx_s;
            entry_r <= entry_nx_s;
            exit_r  <= exit_nx_s;
            id_r    <= id_nx_s;
            start_r <= start_nx_s;
            busy_r  <= busy_nx_s;
        end
    end

    assign lane_grant      = grant_r;
    assign lane_done       = done_r;
    assign lane_fee        = fee_r;
    assign lane_error      = error_r;
    assign calc_entry_time = entry_r;
    assign calc_exit_time  = exit_r;
    assign calc_vehicle_id = id_r;
    assign calculate_fee   = start_r;
    assign busy            = busy_r;

endmodule
